// File: rtl/demux_1s2_stream.sv
// Registered 1-to-2 stream demultiplexer with packet lock.
// The route comes from s0 on a packet's first beat. It is held in sel_q until
// the last beat is accepted. Each output owns a one-entry slot, so a stalled
// consumer only blocks input beats that are routed to it.
module demux_1s2_stream #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  input  logic          s0,
  output logic          y0_valid,
  input  logic          y0_ready,
  output logic [DW-1:0] y0_data,
  output logic          y0_last,
  output logic          y1_valid,
  input  logic          y1_ready,
  output logic [DW-1:0] y1_data,
  output logic          y1_last,
  output logic [CW-1:0] pkt_cnt0,
  output logic [CW-1:0] pkt_cnt1
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t state;
  logic   sel_q;
  logic   route;
  logic   accept;
  logic   load0;
  logic   load1;
  logic   drain0;
  logic   drain1;

  // In IDLE the live select steers the first beat; in LOCK the captured one does.
  assign route  = (state == LOCK) ? sel_q : s0;

  // A slot can take a beat when it is empty or is being drained in this cycle.
  // The ready path from the consumer back to s_ready is combinational by design.
  assign s_ready = rst_n & (route ? (~y1_valid | y1_ready) : (~y0_valid | y0_ready));

  assign accept = s_valid & s_ready;
  assign load0  = accept & ~route;
  assign load1  = accept & route;
  assign drain0 = y0_valid & y0_ready;
  assign drain1 = y1_valid & y1_ready;

  // Route FSM: capture the select on every accepted beat and lock it until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else if (accept) begin
      sel_q <= route;
      state <= s_last ? IDLE : LOCK;
    end
  end

  // Y0 slot: a reload wins over a drain, so back-to-back beats keep valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_valid <= 1'b0;
      y0_data  <= '0;
      y0_last  <= 1'b0;
    end else if (load0) begin
      y0_valid <= 1'b1;
      y0_data  <= s_data;
      y0_last  <= s_last;
    end else if (drain0) begin
      y0_valid <= 1'b0;
    end
  end

  // Y1 slot: same behaviour as Y0, and it drains independently of Y0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_valid <= 1'b0;
      y1_data  <= '0;
      y1_last  <= 1'b0;
    end else if (load1) begin
      y1_valid <= 1'b1;
      y1_data  <= s_data;
      y1_last  <= s_last;
    end else if (drain1) begin
      y1_valid <= 1'b0;
    end
  end

  // Count packets delivered to each output (last-beat handshakes), wrapping modulo 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (drain0 && y0_last) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (drain1 && y1_last) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1s2_stream.sv
// Testbench for demux_1s2_stream. Stimulus pushes expected beats into per-output
// queues. A monitor on the falling edge compares and pops whatever the DUT presents.
module tb_demux_1s2_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       s0 = 1'b0;
  logic       y0_valid, y1_valid;
  logic       y0_ready = 1'b0, y1_ready = 1'b0;
  logic [7:0] y0_data, y1_data;
  logic       y0_last, y1_last;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: expected {last,data} per output, packet counts, and packet route.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] exp_cnt0 = '0;
  logic [7:0] exp_cnt1 = '0;
  bit         in_pkt = 1'b0;
  bit         pkt_route = 1'b0;

  demux_1s2_stream #(.DW(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s0(s0),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data), .y0_last(y0_last),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data), .y1_last(y1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output slot must match the head of its queue; handshakes pop it.
  always @(negedge clk) begin
    logic [8:0] e;
    chk("pkt_cnt0", {24'd0, pkt_cnt0}, {24'd0, exp_cnt0});
    chk("pkt_cnt1", {24'd0, pkt_cnt1}, {24'd0, exp_cnt1});
    chk("y0_valid", {31'd0, y0_valid}, {31'd0, q0.size() != 0});
    chk("y1_valid", {31'd0, y1_valid}, {31'd0, q1.size() != 0});
    if (y0_valid && q0.size() != 0) begin
      chk("y0_beat", {23'd0, y0_last, y0_data}, {23'd0, q0[0]});
      if (y0_ready) begin
        e = q0.pop_front();
        if (e[8]) exp_cnt0 = exp_cnt0 + 8'd1;
      end
    end
    if (y1_valid && q1.size() != 0) begin
      chk("y1_beat", {23'd0, y1_last, y1_data}, {23'd0, q1[0]});
      if (y1_ready) begin
        e = q1.pop_front();
        if (e[8]) exp_cnt1 = exp_cnt1 + 8'd1;
      end
    end
  end

  // One clock of stimulus, entered and left just after a rising edge.
  // After the monitor has popped this cycle's drains, a slot can take a beat
  // only if its queue is now empty.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic s,
                      input logic r0, input logic r1, output bit acc);
    bit r;
    s_valid = v; s_data = d; s_last = l; s0 = s; y0_ready = r0; y1_ready = r1;
    @(negedge clk); #1;
    r = in_pkt ? pkt_route : s;
    chk("s_ready", {31'd0, s_ready},
        {31'd0, rst_n && (r ? (q1.size() == 0) : (q0.size() == 0))});
    acc = s_valid && s_ready;
    if (acc) begin
      if (r) q1.push_back({l, d}); else q0.push_back({l, d});
      in_pkt = !l;
      pkt_route = r;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic s,
                      input logic r0, input logic r1);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, d, l, s, r0, r1, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: beat 0x%0h never accepted", d);
    end
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, r0, r1, acc);
  endtask

  task automatic do_reset();
    bit acc;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    exp_cnt0 = '0; exp_cnt1 = '0;
    in_pkt = 1'b0; pkt_route = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    chk("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
    chk("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
    chk("rst_cnt0", {24'd0, pkt_cnt0}, 32'd0);
    chk("rst_cnt1", {24'd0, pkt_cnt1}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    logic [7:0] c0_before;
    @(posedge clk); #1;

    // Reset, then the first edge after release must raise s_ready
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);

    // Lock: s0 toggles after the first beat but all beats stay on Y0
    send(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h12, 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'h13, 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'h14, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    chk("lock_cnt0", {24'd0, pkt_cnt0}, 32'd1);
    chk("lock_cnt1", {24'd0, pkt_cnt1}, 32'd0);

    // Back-pressure: Y0 stalled, slot fills, s_ready drops, data holds
    step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    chk("bp_hold_data", {24'd0, y0_data}, 32'h21);
    send(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'h23, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    chk("bp_cnt0", {24'd0, pkt_cnt0}, 32'd2);

    // Independence: Y1 holds a beat while a single-beat packet passes on Y0
    send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    chk("ind_y1_valid", {31'd0, y1_valid}, 32'd1);
    chk("ind_y1_data", {24'd0, y1_data}, 32'h3C);
    chk("ind_cnt0", {24'd0, pkt_cnt0}, 32'd3);
    idle(2, 1'b1, 1'b1);

    // Counter wrap: 256 single-beat packets to Y1
    c0_before = pkt_cnt0;
    for (int i = 0; i < 256; i++) send(i[7:0], 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    chk("wrap_cnt1", {24'd0, pkt_cnt1}, 32'd1);
    chk("wrap_cnt0", {24'd0, pkt_cnt0}, {24'd0, c0_before});

    // Mid-packet reset: Y1 packet cut after beat 2 (Y1 stalled so a beat is held)
    send(8'h51, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b1);
    send(8'h52, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    send(8'h61, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h62, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    chk("mr_cnt0", {24'd0, pkt_cnt0}, 32'd1);
    chk("mr_cnt1", {24'd0, pkt_cnt1}, 32'd0);

    // Randomized traffic with random back-pressure on both outputs
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, acc);
    end
    idle(4, 1'b1, 1'b1);
    chk("final_q0_empty", q0.size(), 32'd0);
    chk("final_q1_empty", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1s2_stream.md
# demux_1s2_stream

Registered 1-to-2 stream demultiplexer with packet lock. It steers a single valid/ready input stream to one of two output channels, Y0 or Y1. The route is chosen by select input `s0`, which is sampled on the first beat of each packet and held until that packet's last beat. It is the receive-side counterpart of the 2:1 select cell in the digital library, used wherever a shared data path fans back out to two consumers.

## Interface
- `DW`, default 8: data width in bits.
- `CW`, default 8: width of each per-output packet counter.

- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when high together with `s_valid`.
- `s_data` in DW: input data.
- `s_last` in 1: final beat of the packet.
- `s0` in 1: route select (0 → Y0, 1 → Y1); sampled only on a packet's first beat.
- `y0_valid` / `y1_valid` out 1: output beat valid.
- `y0_ready` / `y1_ready` in 1: downstream ready.
- `y0_data` / `y1_data` out DW: output data.
- `y0_last` / `y1_last` out 1: output last flag.
- `pkt_cnt0` / `pkt_cnt1` out CW: count of completed packets delivered to Y0 / Y1.

## Operation
- Each output has a one-entry register slot holding valid, data and last.
- Route FSM has two states:
  - IDLE: route = `s0`. On an accepted beat, `sel_q` is loaded from `s0`. If `s_last`=0, go to LOCK; otherwise stay in IDLE.
  - LOCK: route = `sel_q`, and `s0` is ignored. An accepted beat with `s_last`=1 returns to IDLE.
- `s_ready` = `rst_n` AND (routed slot empty OR (routed slot valid AND routed `y*_ready`)).
  - This is a combinational path from `y*_ready` to `s_ready`; it is permitted.
- Input accept: the routed slot loads `s_data` and `s_last` and sets valid at the next edge. The non-routed slot is untouched by the input.
- Output drain: `y*_valid` AND `y*_ready` clears the slot, unless the slot is reloaded in the same cycle.
  - Simultaneous drain and reload keeps valid=1 with the new data.
- Both slots drain independently. A stalled Y1 never blocks draining of Y0, and vice versa.
- Packet counters:
  - `pkt_cnt0` increments when a Y0 beat with `y0_last`=1 is handshaken; `pkt_cnt1` likewise for Y1.
  - Counters are modulo 2^CW and wrap from all-ones to 0.
- Output data and last hold stable while valid=1 and ready=0. Valid never drops without a handshake.
- Single-beat packets (first beat has `s_last`=1) never enter LOCK.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - `y0_valid` = `y1_valid` = 0; `y*_data` = 0; `y*_last` = 0.
  - `pkt_cnt0` = `pkt_cnt1` = 0; FSM = IDLE; `sel_q` = 0.
  - `s_ready` = 0 while `rst_n` is low.
- Latency: an input beat accepted at edge N appears on `y*_valid`/`data` after edge N and can be handshaken in cycle N+1.
- Throughput: 1 beat/cycle per packet when the routed consumer holds ready=1.
- Reset mid-packet: the slot contents and the lock are discarded. The first beat after reset is treated as a new packet start.
- `s0` changing mid-packet has no effect until the beat after the accepted last beat.
- Back-to-back packets to different outputs: the last beat of packet A and the first beat of packet B may be accepted on consecutive cycles. B's route comes from `s0` in the cycle B is accepted.

## Test plan
- Reset check: hold `rst_n`=0 with `s_valid`=1 → `s_ready`=0, all valids 0, both counters 0. After release and first edge, `s_ready`=1.
- Lock check: 4-beat packet with data 0x11..0x14, `s0`=0 on beat 1 and toggled to 1 on beats 2–4, `y0_ready`=1 → all four beats appear on Y0 one cycle after acceptance. `y1_valid` stays 0 and `pkt_cnt0`=1.
- Back-pressure: Y0 packet in flight with `y0_ready`=0 → `s_ready`=0 after the slot fills and `y0_data` holds. Raise `y0_ready` → transfer resumes with no loss or duplication.
- Independence: Y1 stalled holding a beat, then a single-beat packet 0xA5 with `s0`=0 → accepted and delivered on Y0 while Y1 stays valid with unchanged data.
- Counter wrap: CW=8, send 256 single-beat packets to Y1 → `pkt_cnt1` returns to 0 and `pkt_cnt0` stays unchanged.
- Mid-packet reset: assert `rst_n`=0 after beat 2 of a Y1 packet, then send a packet with `s0`=0 → it routes to Y0, no stale Y1 beat is emitted, and the counters restart from 0.
